forward_history_buffer: RTL and testbench



---
 rtl/forward_history_buffer_pkg.sv | 33 +++
 rtl/forward_history_buffer_if.sv | 46 ++++
 rtl/forward_history_lane.sv | 88 ++++++++
 rtl/forward_history_buffer.sv | 86 ++++++++
 tb/tb_forward_history_buffer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/forward_history_buffer_pkg.sv
// Shared types for the forward history: one recorded RAM write per table and
// one recorded inter-table shift per table boundary, plus address masking.
package hash_pkg;

    localparam int DATA_WIDTH         = 4;
    localparam int KEY_WIDTH          = 2;
    localparam int MAX_HASH_ADR_WIDTH = 2;

    typedef logic [MAX_HASH_ADR_WIDTH-1:0] hash_adr_t;

    typedef struct packed {
        hash_adr_t             hash_adr;
        logic [DATA_WIDTH-1:0] data;
        logic [KEY_WIDTH-1:0]  key;
        logic                  valid;
        logic                  updated_mem;
    } fwd_entry_t;

    typedef struct packed {
        hash_adr_t hash_adr;
        logic      valid;
    } fwd_shift_t;

    // Clears every address bit at or above the table's own address width.
    function automatic hash_adr_t mask_adr(hash_adr_t adr, int width);
        hash_adr_t m;
        for (int b = 0; b < MAX_HASH_ADR_WIDTH; b++) begin
            m[b] = (b < width) ? adr[b] : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/forward_history_buffer_if.sv
// Bundle between the insert/write-back stage, the history buffer and
// whole_forward_updater. master drives the commit side, slave is the buffer.
interface forward_history_buffer_if #(
    parameter int NUMBER_OF_TABLES       = 3,
    parameter int FORWARDED_CLOCK_CYCLES = 2
);
    import hash_pkg::*;

    localparam int NT = NUMBER_OF_TABLES;
    localparam int NS = NUMBER_OF_TABLES - 1;
    localparam int NA = FORWARDED_CLOCK_CYCLES;

    logic                                 clk_en;
    logic                                 flush_i;
    logic [NT-1:0]                        wr_en_i;
    hash_adr_t [NT-1:0]                   wr_hash_adr_i;
    logic [NT-1:0][DATA_WIDTH-1:0]        wr_data_i;
    logic [NT-1:0][KEY_WIDTH-1:0]         wr_key_i;
    logic [NT-1:0]                        wr_valid_i;
    logic [NS-1:0]                        shift_en_i;
    hash_adr_t [NS-1:0]                   shift_adr_i;

    hash_adr_t [NA-1:0][NT-1:0]           hist_hash_adr_o;
    logic [NA-1:0][NT-1:0][DATA_WIDTH-1:0] hist_data_o;
    logic [NA-1:0][NT-1:0][KEY_WIDTH-1:0] hist_key_o;
    logic [NA-1:0][NT-1:0]                hist_updated_mem_o;
    logic [NA-1:0][NT-1:0]                hist_valid_o;
    hash_adr_t [NA-1:0][NS-1:0]           hist_shift_hash_adr_o;
    logic [NA-1:0][NS-1:0]                hist_shift_valid_o;
    logic                                 pending_o;

    modport master (
        output clk_en, flush_i, wr_en_i, wr_hash_adr_i, wr_data_i, wr_key_i,
               wr_valid_i, shift_en_i, shift_adr_i,
        input  hist_hash_adr_o, hist_data_o, hist_key_o, hist_updated_mem_o,
               hist_valid_o, hist_shift_hash_adr_o, hist_shift_valid_o, pending_o
    );

    modport slave (
        input  clk_en, flush_i, wr_en_i, wr_hash_adr_i, wr_data_i, wr_key_i,
               wr_valid_i, shift_en_i, shift_adr_i,
        output hist_hash_adr_o, hist_data_o, hist_key_o, hist_updated_mem_o,
               hist_valid_o, hist_shift_hash_adr_o, hist_shift_valid_o, pending_o
    );

endinterface

// File: rtl/forward_history_lane.sv
// One table's age-ordered history: a shift register of committed writes and,
// unless this is the last table, of shifts out of this table into the next.
module forward_history_lane
    import hash_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int ADR_W     = 2,
    parameter bit HAS_SHIFT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   flush,
    input  logic                   wr_en,
    input  hash_adr_t              wr_adr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [KEY_WIDTH-1:0]   wr_key,
    input  logic                   wr_valid,
    input  logic                   shift_en,
    input  hash_adr_t              shift_adr,
    output fwd_entry_t [DEPTH-1:0] hist,
    output fwd_shift_t [DEPTH-1:0] shift_hist,
    output logic                   pending
);

    fwd_entry_t [DEPTH-1:0] ent_q, ent_d;
    fwd_shift_t [DEPTH-1:0] sh_q, sh_d;

    // Next history: age on clk_en, capture age 0, then apply flush to flags.
    always_comb begin
        // NOTE: start from the held value so every path assigns; no latch.
        ent_d = ent_q;
        sh_d  = sh_q;
        if (clk_en) begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_d[k] = ent_q[k-1];
                sh_d[k]  = sh_q[k-1];
            end
            ent_d[0] = '{hash_adr:    mask_adr(wr_adr, ADR_W),
                         data:        wr_data,
                         key:         wr_key,
                         valid:       wr_valid,
                         updated_mem: wr_en};
            sh_d[0]  = '{hash_adr: mask_adr(shift_adr, ADR_W),
                         valid:    shift_en};
        end
        if (flush) begin
            // Age 0 survives a flush only when it is this cycle's committed write.
            for (int k = 1; k < DEPTH; k++) begin
                ent_d[k].updated_mem = 1'b0;
                sh_d[k].valid        = 1'b0;
            end
            if (!clk_en) begin
                ent_d[0].updated_mem = 1'b0;
                sh_d[0].valid        = 1'b0;
            end
        end
        if (!HAS_SHIFT) begin
            sh_d = '0;
        end
    end

    // History registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the whole history is reset, not just the flags, so the
            // don't-care fields read back as 0 after reset.
            ent_q <= '0;
            sh_q  <= '0;
        end else begin
            // NOTE: non-blocking so every age samples the pre-edge value.
            ent_q <= ent_d;
            sh_q  <= sh_d;
        end
    end

    // Any live record in this lane.
    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            pending = pending | ent_q[k].updated_mem | sh_q[k].valid;
        end
    end

    assign hist       = ent_q;
    assign shift_hist = sh_q;

endmodule

// File: rtl/forward_history_buffer.sv
// Forward history for stale-read correction: one lane per cuckoo table,
// outputs reordered to [age][table] for whole_forward_updater.
module forward_history_buffer
    import hash_pkg::*;
#(
    parameter int NUMBER_OF_TABLES       = 3,
    parameter int FORWARDED_CLOCK_CYCLES = 2,
    parameter logic [NUMBER_OF_TABLES-1:0][31:0] HASH_TABLE_ADR_WIDTH =
        {32'd2, 32'd2, 32'd2}
) (
    input  logic                     clk,
    input  logic                     reset,
    forward_history_buffer_if.slave  bus
);

    localparam int NT = NUMBER_OF_TABLES;
    localparam int NA = FORWARDED_CLOCK_CYCLES;

    fwd_entry_t [NT-1:0][NA-1:0] lane_hist;
    fwd_shift_t [NT-1:0][NA-1:0] lane_shift;
    logic [NT-1:0]               lane_pending;
    logic [NT-1:0]               lane_shift_en;
    hash_adr_t [NT-1:0]          lane_shift_adr;

    // Route boundary shifts to their source table; the last table has none.
    always_comb begin
        lane_shift_en  = '0;
        lane_shift_adr = '0;
        for (int i = 0; i < NT - 1; i++) begin
            lane_shift_en[i]  = bus.shift_en_i[i];
            lane_shift_adr[i] = bus.shift_adr_i[i];
        end
    end

    for (genvar i = 0; i < NT; i++) begin : g_lane
        forward_history_lane #(
            .DEPTH     (NA),
            .ADR_W     (int'(HASH_TABLE_ADR_WIDTH[i])),
            .HAS_SHIFT (i < NT - 1)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .clk_en     (bus.clk_en),
            .flush      (bus.flush_i),
            .wr_en      (bus.wr_en_i[i]),
            .wr_adr     (bus.wr_hash_adr_i[i]),
            .wr_data    (bus.wr_data_i[i]),
            .wr_key     (bus.wr_key_i[i]),
            .wr_valid   (bus.wr_valid_i[i]),
            .shift_en   (lane_shift_en[i]),
            .shift_adr  (lane_shift_adr[i]),
            .hist       (lane_hist[i]),
            .shift_hist (lane_shift[i]),
            .pending    (lane_pending[i])
        );
    end

    // Reorder lane histories from [table][age] into [age][table].
    always_comb begin
        bus.hist_hash_adr_o       = '0;
        bus.hist_data_o           = '0;
        bus.hist_key_o            = '0;
        bus.hist_updated_mem_o    = '0;
        bus.hist_valid_o          = '0;
        bus.hist_shift_hash_adr_o = '0;
        bus.hist_shift_valid_o    = '0;
        for (int a = 0; a < NA; a++) begin
            for (int i = 0; i < NT; i++) begin
                bus.hist_hash_adr_o[a][i]    = lane_hist[i][a].hash_adr;
                bus.hist_data_o[a][i]        = lane_hist[i][a].data;
                bus.hist_key_o[a][i]         = lane_hist[i][a].key;
                bus.hist_valid_o[a][i]       = lane_hist[i][a].valid;
                bus.hist_updated_mem_o[a][i] = lane_hist[i][a].updated_mem;
            end
            for (int s = 0; s < NT - 1; s++) begin
                bus.hist_shift_hash_adr_o[a][s] = lane_shift[s][a].hash_adr;
                bus.hist_shift_valid_o[a][s]    = lane_shift[s][a].valid;
            end
        end
    end

    // The last lane's shift record is constant zero; folding it in keeps every
    // lane output consumed without changing the result.
    assign bus.pending_o = (|lane_pending) | (|lane_shift[NT-1]);

endmodule

// File: tb/tb_forward_history_buffer.sv
// Bench for forward_history_buffer: directed vector table, hand sequences for
// the multi-cycle corners, then random traffic against a queue-based model.
// A second instance uses narrower table-1 addressing to exercise masking.
module tb_forward_history_buffer;
    import hash_pkg::*;

    localparam int NT  = 3;
    localparam int NS  = NT - 1;
    localparam int NA  = 2;
    localparam int MAW = MAX_HASH_ADR_WIDTH;
    localparam logic [NT-1:0][31:0] W_DEF = {32'd2, 32'd2, 32'd2};
    localparam logic [NT-1:0][31:0] W_MSK = {32'd2, 32'd1, 32'd2};

    typedef logic [NT-1:0][31:0]                  wvec_t;
    typedef logic [NA-1:0][NT-1:0][MAW-1:0]        adr_vec_t;
    typedef logic [NA-1:0][NT-1:0][DATA_WIDTH-1:0] data_vec_t;
    typedef logic [NA-1:0][NT-1:0][KEY_WIDTH-1:0]  key_vec_t;
    typedef logic [NA-1:0][NT-1:0]                 flag_vec_t;
    typedef logic [NA-1:0][NS-1:0][MAW-1:0]        sadr_vec_t;
    typedef logic [NA-1:0][NS-1:0]                 sflag_vec_t;

    // One committed cycle as seen at the inputs.
    typedef struct {
        logic [NT-1:0]                 upd;
        logic [NT-1:0][MAW-1:0]        adr;
        logic [NT-1:0][DATA_WIDTH-1:0] data;
        logic [NT-1:0][KEY_WIDTH-1:0]  key;
        logic [NT-1:0]                 vld;
        logic [NS-1:0]                 sv;
        logic [NS-1:0][MAW-1:0]        sadr;
    } rec_t;

    typedef struct {
        logic          rst;
        logic          ce;
        logic          fl;
        logic [NT-1:0] we;
        logic [MAW-1:0] adr;
        logic [NS-1:0] se;
        logic [5:0]    e_upd;
        logic [3:0]    e_sv;
        logic          e_pend;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    forward_history_buffer_if #(.NUMBER_OF_TABLES(NT), .FORWARDED_CLOCK_CYCLES(NA)) bus ();
    forward_history_buffer_if #(.NUMBER_OF_TABLES(NT), .FORWARDED_CLOCK_CYCLES(NA)) bus_m ();

    assign bus_m.clk_en        = bus.clk_en;
    assign bus_m.flush_i       = bus.flush_i;
    assign bus_m.wr_en_i       = bus.wr_en_i;
    assign bus_m.wr_hash_adr_i = bus.wr_hash_adr_i;
    assign bus_m.wr_data_i     = bus.wr_data_i;
    assign bus_m.wr_key_i      = bus.wr_key_i;
    assign bus_m.wr_valid_i    = bus.wr_valid_i;
    assign bus_m.shift_en_i    = bus.shift_en_i;
    assign bus_m.shift_adr_i   = bus.shift_adr_i;

    forward_history_buffer #(
        .NUMBER_OF_TABLES(NT), .FORWARDED_CLOCK_CYCLES(NA), .HASH_TABLE_ADR_WIDTH(W_DEF)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    forward_history_buffer #(
        .NUMBER_OF_TABLES(NT), .FORWARDED_CLOCK_CYCLES(NA), .HASH_TABLE_ADR_WIDTH(W_MSK)
    ) dut_m (.clk(clk), .reset(reset), .bus(bus_m));

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t stim;
    rec_t m_q[$];
    logic ce, fl;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t zero_rec();
        rec_t z;
        z.upd = '0; z.adr = '0; z.data = '0; z.key = '0;
        z.vld = '0; z.sv = '0; z.sadr = '0;
        return z;
    endfunction

    // History model: newest cycle at the front, exactly NA cycles kept.
    task automatic model_edge();
        if (reset) begin
            m_q.delete();
            for (int a = 0; a < NA; a++) m_q.push_back(zero_rec());
        end else begin
            if (ce) begin
                m_q.push_front(stim);
                void'(m_q.pop_back());
            end
            if (fl) begin
                for (int a = (ce ? 1 : 0); a < NA; a++) begin
                    m_q[a].upd = '0;
                    m_q[a].sv  = '0;
                end
            end
        end
    endtask

    task automatic drive();
        reset             = reset;
        bus.clk_en        = ce;
        bus.flush_i       = fl;
        bus.wr_en_i       = stim.upd;
        bus.wr_hash_adr_i = stim.adr;
        bus.wr_data_i     = stim.data;
        bus.wr_key_i      = stim.key;
        bus.wr_valid_i    = stim.vld;
        bus.shift_en_i    = stim.sv;
        bus.shift_adr_i   = stim.sadr;
    endtask

    function automatic logic [MAW-1:0] masked(logic [MAW-1:0] a, logic [31:0] w);
        logic [31:0] lim;
        logic [31:0] full;
        lim  = (32'd1 << w) - 32'd1;
        full = {{(32-MAW){1'b0}}, a} & lim;
        return full[MAW-1:0];
    endfunction

    task automatic check_one(string tag, wvec_t w, adr_vec_t g_adr, data_vec_t g_data,
                             key_vec_t g_key, flag_vec_t g_vld, flag_vec_t g_upd,
                             sadr_vec_t g_sadr, sflag_vec_t g_sv, logic g_pend);
        adr_vec_t   e_adr;
        data_vec_t  e_data;
        key_vec_t   e_key;
        flag_vec_t  e_vld, e_upd;
        sadr_vec_t  e_sadr;
        sflag_vec_t e_sv;
        for (int a = 0; a < NA; a++) begin
            for (int i = 0; i < NT; i++) begin
                e_adr[a][i]  = masked(m_q[a].adr[i], w[i]);
                e_data[a][i] = m_q[a].data[i];
                e_key[a][i]  = m_q[a].key[i];
                e_vld[a][i]  = m_q[a].vld[i];
                e_upd[a][i]  = m_q[a].upd[i];
            end
            for (int s = 0; s < NS; s++) begin
                e_sadr[a][s] = masked(m_q[a].sadr[s], w[s]);
                e_sv[a][s]   = m_q[a].sv[s];
            end
        end
        check({tag, "_adr"},     64'(g_adr),  64'(e_adr));
        check({tag, "_data"},    64'(g_data), 64'(e_data));
        check({tag, "_key"},     64'(g_key),  64'(e_key));
        check({tag, "_valid"},   64'(g_vld),  64'(e_vld));
        check({tag, "_updated"}, 64'(g_upd),  64'(e_upd));
        check({tag, "_sadr"},    64'(g_sadr), 64'(e_sadr));
        check({tag, "_svalid"},  64'(g_sv),   64'(e_sv));
        check({tag, "_pending"}, 64'(g_pend), 64'((|e_upd) | (|e_sv)));
    endtask

    task automatic check_all();
        check_one("dut", W_DEF, bus.hist_hash_adr_o, bus.hist_data_o, bus.hist_key_o,
                  bus.hist_valid_o, bus.hist_updated_mem_o, bus.hist_shift_hash_adr_o,
                  bus.hist_shift_valid_o, bus.pending_o);
        check_one("msk", W_MSK, bus_m.hist_hash_adr_o, bus_m.hist_data_o, bus_m.hist_key_o,
                  bus_m.hist_valid_o, bus_m.hist_updated_mem_o, bus_m.hist_shift_hash_adr_o,
                  bus_m.hist_shift_valid_o, bus_m.pending_o);
    endtask

    // Drive, update the model for this edge, advance, sample #1 after the edge.
    task automatic tick();
        drive();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_write(logic [NT-1:0] we, logic [MAW-1:0] adr, logic [NS-1:0] se);
        stim.upd = we;
        for (int i = 0; i < NT; i++) begin
            stim.adr[i]  = adr;
            stim.data[i] = 4'd5;
            stim.key[i]  = 2'd3;
            stim.vld[i]  = 1'b1;
        end
        stim.sv = se;
        for (int s = 0; s < NS; s++) stim.sadr[s] = 2'd3;
    endtask

    vec_t vt[21];

    initial begin
        reset = 1'b1; ce = 1'b1; fl = 1'b0;
        stim = zero_rec();
        m_q.delete();
        for (int a = 0; a < NA; a++) m_q.push_back(zero_rec());

        //        rst   ce    fl    we      adr   se     upd    sv     pend
        vt[0]  = '{1'b1, 1'b1, 1'b1, 3'b111, 2'd2, 2'b11, 6'h00, 4'h0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 3'b010, 2'd2, 2'b00, 6'h02, 4'h0, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'b00, 6'h10, 4'h0, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'b00, 6'h00, 4'h0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'b01, 6'h00, 4'h1, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'b00, 6'h00, 4'h4, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'b00, 6'h00, 4'h0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 3'b001, 2'd2, 2'b00, 6'h01, 4'h0, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 3'b111, 2'd1, 2'b11, 6'h01, 4'h0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 3'b111, 2'd1, 2'b11, 6'h01, 4'h0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 3'b111, 2'd1, 2'b11, 6'h01, 4'h0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 3'b111, 2'd1, 2'b11, 6'h01, 4'h0, 1'b1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 3'b111, 2'd1, 2'b11, 6'h01, 4'h0, 1'b1};
        vt[13] = '{1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'b00, 6'h08, 4'h0, 1'b1};
        vt[14] = '{1'b0, 1'b1, 1'b0, 3'b111, 2'd2, 2'b11, 6'h07, 4'h3, 1'b1};
        vt[15] = '{1'b0, 1'b1, 1'b0, 3'b111, 2'd3, 2'b11, 6'h3F, 4'hF, 1'b1};
        vt[16] = '{1'b0, 1'b1, 1'b1, 3'b001, 2'd1, 2'b00, 6'h01, 4'h0, 1'b1};
        vt[17] = '{1'b0, 1'b1, 1'b0, 3'b100, 2'd2, 2'b00, 6'h0C, 4'h0, 1'b1};
        vt[18] = '{1'b0, 1'b0, 1'b1, 3'b000, 2'd2, 2'b00, 6'h00, 4'h0, 1'b0};
        vt[19] = '{1'b0, 1'b1, 1'b0, 3'b111, 2'd2, 2'b00, 6'h07, 4'h0, 1'b1};
        vt[20] = '{1'b1, 1'b1, 1'b0, 3'b111, 2'd2, 2'b11, 6'h00, 4'h0, 1'b0};

        for (int v = 0; v < 21; v++) begin
            reset = vt[v].rst; ce = vt[v].ce; fl = vt[v].fl;
            set_write(vt[v].we, vt[v].adr, vt[v].se);
            tick();
            check($sformatf("vec%0d_updated", v), 64'(bus.hist_updated_mem_o), 64'(vt[v].e_upd));
            check($sformatf("vec%0d_svalid", v),  64'(bus.hist_shift_valid_o), 64'(vt[v].e_sv));
            check($sformatf("vec%0d_pending", v), 64'(bus.pending_o),          64'(vt[v].e_pend));
        end

        // Single write on table 1: visible at age 0, then age 1, then gone.
        reset = 1'b0; ce = 1'b1; fl = 1'b0;
        set_write(3'b010, 2'd2, 2'b00);
        tick();
        check("single_age0_adr",  64'(bus.hist_hash_adr_o[0][1]), 64'd2);
        check("single_age0_data", 64'(bus.hist_data_o[0][1]),     64'd5);
        check("single_age0_key",  64'(bus.hist_key_o[0][1]),      64'd3);
        check("single_age0_vld",  64'(bus.hist_valid_o[0][1]),    64'd1);
        set_write(3'b000, 2'd0, 2'b00);
        tick();
        check("single_age1_adr",  64'(bus.hist_hash_adr_o[1][1]),    64'd2);
        check("single_age1_data", 64'(bus.hist_data_o[1][1]),        64'd5);
        check("single_age1_upd",  64'(bus.hist_updated_mem_o[1][1]), 64'd1);
        check("single_age0_upd",  64'(bus.hist_updated_mem_o[0][1]), 64'd0);
        tick();
        check("single_gone_pend", 64'(bus.pending_o), 64'd0);

        // Masking: table 1 is one bit wide in the second instance.
        set_write(3'b010, 2'd3, 2'b00);
        tick();
        check("mask_tbl1_adr", 64'(bus_m.hist_hash_adr_o[0][1]), 64'd1);
        check("nomask_tbl1_adr", 64'(bus.hist_hash_adr_o[0][1]), 64'd3);

        // Random traffic with occasional reset, stall and flush.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] r;
            r = $urandom();
            reset = (r[5:0] == 6'd0);
            ce    = (r[7:6] != 2'b00);
            fl    = (r[10:8] == 3'b000);
            r = $urandom(); stim.upd  = r[NT-1:0]; stim.sv = r[NT+NS-1:NT];
                            stim.vld  = r[2*NT+NS-1:NT+NS];
            r = $urandom(); stim.adr  = r[NT*MAW-1:0]; stim.sadr = r[NT*MAW+NS*MAW-1:NT*MAW];
            r = $urandom(); stim.data = r[NT*DATA_WIDTH-1:0];
                            stim.key  = r[NT*DATA_WIDTH+NT*KEY_WIDTH-1:NT*DATA_WIDTH];
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
